// File: rtl/stream_mux_pkg.sv
// Shared types for the N-to-1 stream multiplexer.
// Mode encoding, FSM state encoding and an index wrap helper.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic int unsigned wrap_idx(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/stream_mux_n_to_1_rr_arbiter.sv
// Rotating-priority pick: the first requester after ptr wins.
// Pure combinational; ptr itself has the lowest priority.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    logic [W-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        // Scan far-to-near so the nearest requester overwrites the rest.
        for (int unsigned off = N; off >= 1; off--) begin
            idx = W'(wrap_idx(32'(ptr), off, N));
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-to-1 packet stream mux with fixed or round-robin selection.
// Grant is held for a whole packet; output is a single register stage.
module stream_mux_n_to_1
    import stream_mux_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CHANNELS*SIZE-1:0] in_data,
    input  logic [CHANNELS-1:0]      in_valid,
    input  logic [CHANNELS-1:0]      in_last,
    output logic [CHANNELS-1:0]      in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [SIZE-1:0]          out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_chan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] arb_idx;
    logic [SEL_W-1:0] cand_idx;
    logic             arb_any;
    logic             cand_any;
    logic             fixed_ok;
    logic             can_take;
    logic             accept;
    logic             pkt_done;
    logic             grant_valid;
    logic             grant_last;
    logic [SIZE-1:0]  grant_data;
    logic [SIZE-1:0]  chan_data [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_split
        assign chan_data[k] = in_data[k*SIZE +: SIZE];
    end

    rr_arbiter #(
        .N(CHANNELS)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // An out-of-range fixed select never produces a candidate.
    always_comb begin
        fixed_ok = 1'b0;
        if (32'(sel) < CHANNELS) begin
            fixed_ok = in_valid[sel];
        end
        cand_any = (mode == MODE_RR) ? arb_any : fixed_ok;
        cand_idx = (mode == MODE_RR) ? arb_idx : sel;
    end

    assign grant_valid = in_valid[grant];
    assign grant_last  = in_last[grant];
    assign grant_data  = chan_data[grant];
    assign can_take    = !out_valid || out_ready;
    assign busy        = (state == ST_LOCKED);
    assign accept      = busy && grant_valid && can_take;
    assign pkt_done    = accept && grant_last;

    always_comb begin
        in_ready = '0;
        if (busy) begin
            in_ready[grant] = can_take;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cand_any) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (pkt_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= SEL_W'(CHANNELS - 1);
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cand_any) begin
                grant <= cand_idx;
            end
            if (pkt_done) begin
                rr_ptr <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_last  <= grant_last;
            out_chan  <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Directed bench for stream_mux_n_to_1: per-channel source queues feed
// the DUT, a monitor records consumed output beats as {chan,last,data}.
module tb_stream_mux_n_to_1;

    localparam int SIZE = 4;
    localparam int CH   = 4;
    localparam int SW   = 2;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic [CH*SIZE-1:0] in_data = '0;
    logic [CH-1:0]    in_valid  = '0;
    logic [CH-1:0]    in_last   = '0;
    logic [CH-1:0]    in_ready;
    logic             mode      = 1'b0;
    logic [SW-1:0]    sel       = '0;
    logic [SIZE-1:0]  out_data;
    logic             out_last;
    logic [SW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy;

    logic [4:0] src_q [CH][$];
    logic [6:0] mon_q [$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_mux_n_to_1 #(
        .SIZE     (SIZE),
        .CHANNELS (CH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Producers and consumer monitor: sample mid-cycle, update after the edge.
    always begin : model
        logic [CH-1:0] hs;
        @(negedge clk);
        hs = in_valid & in_ready;
        if (reset_n && out_valid && out_ready) begin
            mon_q.push_back({out_chan, out_last, out_data});
        end
        @(posedge clk);
        #1;
        if (!reset_n) hs = '0;
        for (int k = 0; k < CH; k++) begin
            if (hs[k] && src_q[k].size() > 0) begin
                void'(src_q[k].pop_front());
            end
            in_valid[k] = src_q[k].size() > 0;
            in_last[k] = (src_q[k].size() > 0) ? src_q[k][0][4] : 1'b0;
            in_data[k*SIZE +: SIZE] =
                (src_q[k].size() > 0) ? src_q[k][0][3:0] : 4'h0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic enter_reset;
        reset_n = 1'b0;
        for (int k = 0; k < CH; k++) src_q[k].delete();
        mon_q.delete();
        out_ready = 1'b1;
        mode = 1'b0;
        sel = '0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 60 && mon_q.size() < n; i++) tick();
    endtask

    task automatic test_reset;
        enter_reset();
        for (int k = 0; k < CH; k++) src_q[k].push_back({1'b1, 4'(k + 1)});
        mode = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_state: got valid=%b busy=%b want 0 0",
                     out_valid, busy);
        end
        n_cmp++;
        if (in_ready !== 4'h0) begin
            n_err++;
            $display("FAIL rst_in_ready: got %h want 0", in_ready);
        end
        n_cmp++;
        if ({out_data, out_last, out_chan} !== 7'h0) begin
            n_err++;
            $display("FAIL rst_out_regs: got %h/%b/%0d want 0/0/0",
                     out_data, out_last, out_chan);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_run: got out_valid=%b want 1", out_valid);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 6'h0) begin
            n_err++;
            $display("FAIL async_clr: got valid=%b busy=%b ready=%h want 0",
                     out_valid, busy, in_ready);
        end
        enter_reset();
    endtask

    task automatic test_fixed;
        logic [6:0] exp [2];
        int ready_bad;
        exp = '{{2'd2, 1'b0, 4'hA}, {2'd2, 1'b1, 4'hB}};
        enter_reset();
        src_q[2].push_back({1'b0, 4'hA});
        src_q[2].push_back({1'b1, 4'hB});
        src_q[0].push_back({1'b1, 4'h1});
        src_q[1].push_back({1'b1, 4'h2});
        src_q[3].push_back({1'b1, 4'h3});
        mode = 1'b0;
        sel = 2'd2;
        tick();
        tick();
        reset_n = 1'b1;
        ready_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((in_ready & 4'b1011) != 4'h0) ready_bad++;
        end
        tick();
        n_cmp++;
        if (ready_bad != 0) begin
            n_err++;
            $display("FAIL fixed_others_ready: got %0d cycles want 0",
                     ready_bad);
        end
        n_cmp++;
        if (mon_q.size() != 2) begin
            n_err++;
            $display("FAIL fixed_count: got %0d want 2", mon_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
                n_err++;
                $display("FAIL fixed_beat%0d: got %h want %h", i,
                         (i < mon_q.size()) ? mon_q[i] : 7'h7f, exp[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_idle_after: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin;
        logic [6:0] exp [5];
        exp = '{{2'd0, 1'b1, 4'h0}, {2'd1, 1'b1, 4'h1},
                {2'd2, 1'b1, 4'h2}, {2'd3, 1'b1, 4'h3},
                {2'd0, 1'b1, 4'h4}};
        enter_reset();
        src_q[0].push_back({1'b1, 4'h0});
        src_q[0].push_back({1'b1, 4'h4});
        src_q[1].push_back({1'b1, 4'h1});
        src_q[2].push_back({1'b1, 4'h2});
        src_q[3].push_back({1'b1, 4'h3});
        mode = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        wait_beats(5);
        tick();
        n_cmp++;
        if (mon_q.size() != 5) begin
            n_err++;
            $display("FAIL rr_count: got %0d want 5", mon_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
                n_err++;
                $display("FAIL rr_beat%0d: got %h want %h", i,
                         (i < mon_q.size()) ? mon_q[i] : 7'h7f, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [6:0] exp [4];
        exp = '{{2'd3, 1'b0, 4'h1}, {2'd3, 1'b0, 4'h2},
                {2'd3, 1'b0, 4'h3}, {2'd3, 1'b1, 4'h4}};
        enter_reset();
        src_q[3].push_back({1'b0, 4'h1});
        src_q[3].push_back({1'b0, 4'h2});
        src_q[3].push_back({1'b0, 4'h3});
        src_q[3].push_back({1'b1, 4'h4});
        mode = 1'b0;
        sel = 2'd3;
        out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 4'h1 ||
                out_chan !== 2'd3 || in_ready !== 4'h0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b d=%h c=%0d rdy=%h want 1 1 3 0",
                         c, out_valid, out_data, out_chan, in_ready);
            end
        end
        tick();
        out_ready = 1'b1;
        wait_beats(4);
        tick();
        tick();
        tick();
        n_cmp++;
        if (mon_q.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d want 4", mon_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
                n_err++;
                $display("FAIL bp_beat%0d: got %h want %h", i,
                         (i < mon_q.size()) ? mon_q[i] : 7'h7f, exp[i]);
            end
        end
    endtask

    task automatic test_packet_lock;
        logic [6:0] exp [4];
        exp = '{{2'd1, 1'b0, 4'h5}, {2'd1, 1'b0, 4'h6},
                {2'd1, 1'b1, 4'h7}, {2'd0, 1'b1, 4'h8}};
        enter_reset();
        src_q[1].push_back({1'b0, 4'h5});
        src_q[1].push_back({1'b0, 4'h6});
        src_q[1].push_back({1'b1, 4'h7});
        src_q[0].push_back({1'b1, 4'h8});
        mode = 1'b0;
        sel = 2'd1;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20 && busy !== 1'b1; i++) tick();
        mode = 1'b1;
        sel = 2'd0;
        wait_beats(4);
        tick();
        tick();
        n_cmp++;
        if (mon_q.size() != 4) begin
            n_err++;
            $display("FAIL lock_count: got %0d want 4", mon_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
                n_err++;
                $display("FAIL lock_beat%0d: got %h want %h", i,
                         (i < mon_q.size()) ? mon_q[i] : 7'h7f, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [6:0] exp [4];
        exp = '{{2'd0, 1'b1, 4'hC}, {2'd1, 1'b1, 4'hD},
                {2'd2, 1'b1, 4'hE}, {2'd3, 1'b1, 4'hF}};
        enter_reset();
        for (int b = 1; b <= 4; b++) src_q[2].push_back({b == 4, 4'(b)});
        mode = 1'b0;
        sel = 2'd2;
        tick();
        tick();
        reset_n = 1'b1;
        wait_beats(2);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 6'h0) begin
            n_err++;
            $display("FAIL mid_rst_clr: got valid=%b busy=%b ready=%h want 0",
                     out_valid, busy, in_ready);
        end
        enter_reset();
        src_q[1].push_back({1'b1, 4'hD});
        src_q[2].push_back({1'b1, 4'hE});
        src_q[0].push_back({1'b1, 4'hC});
        src_q[3].push_back({1'b1, 4'hF});
        mode = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_idle: got out_valid=%b want 0", out_valid);
        end
        wait_beats(4);
        tick();
        n_cmp++;
        if (mon_q.size() != 4) begin
            n_err++;
            $display("FAIL mid_rst_count: got %0d want 4", mon_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
                n_err++;
                $display("FAIL mid_rst_beat%0d: got %h want %h", i,
                         (i < mon_q.size()) ? mon_q[i] : 7'h7f, exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_packet_lock();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
